// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for the 16-bit NITC-RISC24 multicycle
// datapath. The FSM steps through fetch, decode, execute, memory and
// writeback. A mem_ready handshake lets instruction and data memory add
// wait states in FETCH, MEMRD and MEMWR.
//
// Optional feature: define RETIRE_COUNT_EN to add a 16-bit retired-instruction
// counter on output 'retired'. When the macro is not defined there is no
// port and no counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// FETCH   | read instruction at PC; load IR and PC+2 once memory is ready
// DECODE  | read registers; ALUOut <= branch/jump target
// MEMADR  | ALUOut <= A + signimm (LW/SW effective address)
// MEMRD   | data read at ALUOut; wait for mem_ready
// MEMWB   | rf[instr[8:6]] <= data register
// MEMWR   | data write at ALUOut; memwrite is held until mem_ready
// EXEC    | ALU op on A,B (ADD or NAND)
// ALUWB   | rf[instr[5:3]] <= ALUOut
// BRANCH  | A - B; PC <= ALUOut when equal
// JAL     | r7 <= PC; PC <= jump target
// HALT    | illegal opcode trap; only reset leaves this state
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        compare,
  input  logic        mem_ready,
  output logic        pcen,
  output logic        irwrite,
  output logic        regwrite,
  output logic        alusrca,
  output logic        iord,
  output logic        memtoreg,
  output logic        regdst,
  output logic        memwrite,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        halted,
  output logic [3:0]  state
`ifdef RETIRE_COUNT_EN
  ,
  output logic [15:0] retired
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JAL    = 4'd9,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_NAND  = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_PASSA = 3'b011;

  state_t state_q, state_d;
  // ALUWB keeps driving the ALU function that EXEC chose.
  logic   alu_nand_q;
  // A completing state hands control back to FETCH in this cycle.
  logic   retire_evt;

  // Next-state selection from the current state, opcode and memory handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_ADD, OP_NDU: state_d = S_EXEC;
          OP_BEQ:         state_d = S_BRANCH;
          OP_JAL:         state_d = S_JAL;
          default:        state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JAL:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // An instruction retires when its last state returns control to FETCH
  always_comb begin
    retire_evt = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: retire_evt = 1'b1;
      S_MEMWR:                           retire_evt = mem_ready;
      default:                           retire_evt = 1'b0;
    endcase
  end

  // State register plus the ALU function latched in EXEC for ALUWB
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= state_t'(RESET_STATE);
      alu_nand_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EXEC) alu_nand_q <= (op == OP_NDU);
    end
  end

`ifdef RETIRE_COUNT_EN
  logic [15:0] retired_q;

  // Count retired instructions; the counter wraps and holds while in HALT
  always_ff @(posedge clk) begin
    if (reset) retired_q <= 16'd0;
    else if (retire_evt) retired_q <= retired_q + 16'd1;
  end

  assign retired = retired_q;
`endif

  // Moore decode of datapath controls; reset forces every output low at once
  always_comb begin
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    memwrite   = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    halted     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          alusrcb = 2'b01;
          irwrite = mem_ready;
          pcen    = mem_ready;
        end
        S_DECODE: begin
          alusrcb = 2'b11;
          pcsrc   = (op == OP_JAL) ? 2'b10 : 2'b00;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        S_MEMRD: iord = 1'b1;
        S_MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        S_MEMWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_EXEC: begin
          alusrca    = 1'b1;
          alucontrol = (op == OP_NDU) ? ALU_NAND : ALU_ADD;
        end
        S_ALUWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          alucontrol = alu_nand_q ? ALU_NAND : ALU_ADD;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alucontrol = ALU_SUB;
          pcsrc      = 2'b01;
          pcen       = compare;
        end
        S_JAL: begin
          alucontrol = ALU_PASSA;
          pcsrc      = 2'b10;
          regwrite   = 1'b1;
          pcen       = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  assign state = reset ? 4'd0 : state_q;

endmodule
